// File: rtl/mm_accel_pkg.sv
// mm_accel_pkg: shared state encoding, buffer selects and sizing helpers for the tile fetch controller
package mm_accel_pkg;
  typedef enum logic [2:0] {IDLE, REQ_A, DATA_A, REQ_B, DATA_B, HANDOFF, FINISH} state_t;
  localparam logic BUF_SEL_A = 1'b0;
  localparam logic BUF_SEL_B = 1'b1;
  function automatic int beats(input int size, input int elem_w, input int bus_w);
    return size * elem_w / bus_w;
  endfunction
  function automatic int elem_bytes(input int elem_w);
    return elem_w / 8;
  endfunction
  localparam int ELEM_BYTES = elem_bytes(32);
endpackage

// File: rtl/mm_tile_fetch_ctrl_if.sv
// mm_tile_fetch_ctrl_if: DMA request/data, operand-buffer write and tile handoff signals
// master = controller side, slave = DMA engine / operand buffers / compute core side
interface mm_tile_fetch_ctrl_if #(parameter int SIZE = 8, parameter int BUS_W = 256, parameter int ADDR_W = 32);
  logic dma_req_valid;
  logic dma_req_ready;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [7:0] dma_req_beats;
  logic dma_data_valid;
  logic dma_data_ready;
  logic [BUS_W-1:0] dma_data;
  logic dma_data_last;
  logic buf_ready;
  logic buf_wr_en;
  logic buf_sel;
  logic [$clog2(SIZE)-1:0] buf_row;
  logic [7:0] buf_beat;
  logic [BUS_W-1:0] buf_data;
  logic tile_valid;
  logic tile_ready;
  logic tile_last_k;
  modport master (
    output dma_req_valid, dma_req_addr, dma_req_beats, dma_data_ready,
    output buf_wr_en, buf_sel, buf_row, buf_beat, buf_data, tile_valid, tile_last_k,
    input dma_req_ready, dma_data_valid, dma_data, dma_data_last, buf_ready, tile_ready
  );
  modport slave (
    input dma_req_valid, dma_req_addr, dma_req_beats, dma_data_ready,
    input buf_wr_en, buf_sel, buf_row, buf_beat, buf_data, tile_valid, tile_last_k,
    output dma_req_ready, dma_data_valid, dma_data, dma_data_last, buf_ready, tile_ready
  );
endinterface

// File: rtl/mm_addr_gen.sv
// mm_addr_gen: incremental A/B row address generator (adders only, wraps modulo 2^ADDR_W)
// load latches bases/strides; row_next steps the row selected by row_sel (0=A,1=B);
// k_next/n_next/m_next move to the next ki / ni / mi tile and rewind both row pointers
module mm_addr_gen import mm_accel_pkg::*; #(
  parameter int SIZE = 8,
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 32,
  parameter int DIM_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic row_next,
  input  logic row_sel,
  input  logic k_next,
  input  logic n_next,
  input  logic m_next,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [DIM_W-1:0] stride_a,
  input  logic [DIM_W-1:0] stride_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);
  localparam int LG = $clog2(SIZE);
  localparam logic [ADDR_W-1:0] TILE_BYTES = ADDR_W'(SIZE * elem_bytes(ELEM_W));
  logic [ADDR_W-1:0] sa, sb, b0, a_m, a_t, b_n, b_t;
  logic [ADDR_W-1:0] a_m_nxt, a_t_nxt, b_n_nxt, b_t_nxt;
  // a_m: row 0 of the current mi block at ki=0; b_n: row 0 of the current ni column at ki=0
  assign a_m_nxt = a_m + (sa << LG);
  assign a_t_nxt = a_t + TILE_BYTES;
  assign b_n_nxt = b_n + TILE_BYTES;
  assign b_t_nxt = b_t + (sb << LG);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {sa, sb, b0, a_m, a_t, b_n, b_t, addr_a, addr_b} <= '0;
    end else if (load) begin
      sa <= ADDR_W'(stride_a);
      sb <= ADDR_W'(stride_b);
      b0 <= base_b;
      a_m <= base_a;
      a_t <= base_a;
      addr_a <= base_a;
      b_n <= base_b;
      b_t <= base_b;
      addr_b <= base_b;
    end else if (m_next) begin
      a_m <= a_m_nxt;
      a_t <= a_m_nxt;
      addr_a <= a_m_nxt;
      b_n <= b0;
      b_t <= b0;
      addr_b <= b0;
    end else if (n_next) begin
      a_t <= a_m;
      addr_a <= a_m;
      b_n <= b_n_nxt;
      b_t <= b_n_nxt;
      addr_b <= b_n_nxt;
    end else if (k_next) begin
      a_t <= a_t_nxt;
      addr_a <= a_t_nxt;
      b_t <= b_t_nxt;
      addr_b <= b_t_nxt;
    end else if (row_next) begin
      if (row_sel) addr_b <= addr_b + sb;
      else addr_a <= addr_a + sa;
    end
endmodule

// File: rtl/mm_tile_fetch_ctrl.sv
// mm_tile_fetch_ctrl: sequences per-row DMA bursts of A/B operand tiles and hands tile pairs to the compute core
// clk/rst: clock, async active-high reset; start + addr_base_*/stride_*/m/k/n: job configuration (latched on start)
// busy/done/err: job status; bus (master): DMA request/data, operand buffer writes, tile handoff
module mm_tile_fetch_ctrl import mm_accel_pkg::*; #(
  parameter int SIZE = 8,
  parameter int ELEM_W = 32,
  parameter int BUS_W = 256,
  parameter int ADDR_W = 32,
  parameter int DIM_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_W-1:0] addr_base_a,
  input  logic [ADDR_W-1:0] addr_base_b,
  input  logic [DIM_W-1:0] stride_a,
  input  logic [DIM_W-1:0] stride_b,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] k,
  input  logic [DIM_W-1:0] n,
  output logic busy,
  output logic done,
  output logic err,
  mm_tile_fetch_ctrl_if.master bus
);
  localparam int LG = $clog2(SIZE);
  localparam int BEATS = beats(SIZE, ELEM_W, BUS_W);
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [LG-1:0] LAST_ROW = LG'(SIZE - 1);
  state_t state;
  logic [LG-1:0] row;
  logic [7:0] beat;
  logic [DIM_W-1:0] mi, ni, ki, mt, nt, kt;
  logic in_data, acc, beat_last, bad, row_done, hs, k_last, n_last, m_last;
  logic [ADDR_W-1:0] addr_a, addr_b;
  assign in_data = state == DATA_A || state == DATA_B;
  assign bus.dma_data_ready = in_data && bus.buf_ready;
  assign acc = bus.dma_data_ready && bus.dma_data_valid;
  assign beat_last = beat == LAST_BEAT;
  assign bad = acc && (bus.dma_data_last != beat_last);
  assign row_done = acc && beat_last && !bad;
  assign hs = state == HANDOFF && bus.tile_ready;
  assign k_last = ki == kt - 1'b1;
  assign n_last = ni == nt - 1'b1;
  assign m_last = mi == mt - 1'b1;
  assign bus.buf_wr_en = acc;
  assign bus.buf_sel = state == DATA_B ? BUF_SEL_B : BUF_SEL_A;
  assign bus.buf_row = row;
  assign bus.buf_beat = beat;
  assign bus.buf_data = bus.dma_data;
  assign bus.dma_req_beats = 8'(BEATS);
  assign bus.dma_req_addr = state == REQ_B ? addr_b : state == REQ_A ? addr_a : '0;
  mm_addr_gen #(.SIZE(SIZE), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr (
    .clk(clk),
    .rst(rst),
    .load(state == IDLE && start),
    .row_next(row_done),
    .row_sel(state == DATA_B),
    .k_next(hs && !k_last),
    .n_next(hs && k_last && !n_last),
    .m_next(hs && k_last && n_last && !m_last),
    .base_a(addr_base_a),
    .base_b(addr_base_b),
    .stride_a(stride_a),
    .stride_b(stride_b),
    .addr_a(addr_a),
    .addr_b(addr_b)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {busy, done, err} <= '0;
      {bus.dma_req_valid, bus.tile_valid, bus.tile_last_k} <= '0;
      row <= '0;
      beat <= '0;
      {mi, ni, ki, mt, nt, kt} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err <= 1'b0;
          busy <= 1'b1;
          mt <= m >> LG;
          nt <= n >> LG;
          kt <= k >> LG;
          {mi, ni, ki} <= '0;
          row <= '0;
          beat <= '0;
          if (m == '0 || k == '0 || n == '0) begin
            state <= FINISH;
            done <= 1'b1;
          end else begin
            state <= REQ_A;
            bus.dma_req_valid <= 1'b1;
          end
        end
        REQ_A, REQ_B: if (bus.dma_req_ready) begin
          bus.dma_req_valid <= 1'b0;
          state <= state == REQ_A ? DATA_A : DATA_B;
        end
        DATA_A, DATA_B: if (acc) begin
          if (bad) begin
            err <= 1'b1;
            done <= 1'b1;
            state <= FINISH;
            row <= '0;
            beat <= '0;
          end else if (!beat_last) begin
            beat <= beat + 1'b1;
          end else begin
            beat <= '0;
            // SIZE is a power of two, so the last row wraps back to 0 here
            row <= row + 1'b1;
            if (row != LAST_ROW) begin
              state <= state == DATA_A ? REQ_A : REQ_B;
              bus.dma_req_valid <= 1'b1;
            end else if (state == DATA_A) begin
              state <= REQ_B;
              bus.dma_req_valid <= 1'b1;
            end else begin
              state <= HANDOFF;
              bus.tile_valid <= 1'b1;
              bus.tile_last_k <= k_last;
            end
          end
        end
        HANDOFF: if (bus.tile_ready) begin
          bus.tile_valid <= 1'b0;
          bus.tile_last_k <= 1'b0;
          ki <= k_last ? '0 : ki + 1'b1;
          if (k_last) ni <= n_last ? '0 : ni + 1'b1;
          if (k_last && n_last) mi <= m_last ? '0 : mi + 1'b1;
          if (k_last && n_last && m_last) begin
            state <= FINISH;
            done <= 1'b1;
          end else begin
            state <= REQ_A;
            bus.dma_req_valid <= 1'b1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mm_tile_fetch_ctrl.sv
// tb_mm_tile_fetch_ctrl: randomized DMA/buffer/core stalls checked against a loop-order reference model
module tb_mm_tile_fetch_ctrl;
  localparam int SIZE = 8;
  localparam int ELEM_W = 32;
  localparam int BUS_W = 64;
  localparam int ADDR_W = 32;
  localparam int DIM_W = 16;
  localparam int BEATS = SIZE * ELEM_W / BUS_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] addr_base_a = '0, addr_base_b = '0;
  logic [DIM_W-1:0] stride_a = '0, stride_b = '0, m = '0, k = '0, n = '0;
  logic busy, done, err;
  int total = 0;
  int bad = 0;
  mm_tile_fetch_ctrl_if #(.SIZE(SIZE), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) bus ();
  mm_tile_fetch_ctrl #(.SIZE(SIZE), .ELEM_W(ELEM_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .addr_base_a(addr_base_a),
    .addr_base_b(addr_base_b),
    .stride_a(stride_a),
    .stride_b(stride_b),
    .m(m),
    .k(k),
    .n(n),
    .busy(busy),
    .done(done),
    .err(err),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    start = 1'b0;
    bus.dma_req_ready = 1'b0;
    bus.dma_data_valid = 1'b0;
    bus.dma_data_last = 1'b0;
    bus.dma_data = '0;
    bus.buf_ready = 1'b0;
    bus.tile_ready = 1'b0;
  endtask
  task automatic run_job(input logic [31:0] ba, input logic [31:0] bb, input logic [15:0] sa, input logic [15:0] sb,
                         input logic [15:0] mm, input logic [15:0] kk, input logic [15:0] nn,
                         input int err_req, input int rst_req);
    logic [31:0] aq[$];
    logic lq[$];
    logic [31:0] t, prev_addr;
    int mt, kt, nt, reqs, cur, bi, tiles, cyc, j;
    bit pending, stall, fin, abort_wait, tile_wait, inj, wr;
    mt = int'(mm) / SIZE;
    kt = int'(kk) / SIZE;
    nt = int'(nn) / SIZE;
    reqs = 0; cur = -1; bi = 0; tiles = 0; cyc = 0; prev_addr = '0;
    pending = 0; stall = 0; fin = 0; abort_wait = 0; tile_wait = 0;
    for (int mi = 0; mi < mt; mi++)
      for (int ni = 0; ni < nt; ni++)
        for (int ki = 0; ki < kt; ki++) begin
          for (int r = 0; r < SIZE; r++) begin
            t = ba + 32'(mi * SIZE + r) * 32'(sa) + 32'(ki * SIZE * ELEM_W / 8);
            aq.push_back(t);
          end
          for (int r = 0; r < SIZE; r++) begin
            t = bb + 32'(ki * SIZE + r) * 32'(sb) + 32'(ni * SIZE * ELEM_W / 8);
            aq.push_back(t);
          end
          lq.push_back(ki == kt - 1);
        end
    addr_base_a = ba; addr_base_b = bb; stride_a = sa; stride_b = sb; m = mm; k = kk; n = nn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr", err, 0);
    chk("busy_start", busy, 1);
    if (aq.size() == 0) begin
      chk("zero_done", done, 1);
      chk("zero_req", bus.dma_req_valid, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero_idle", busy, 0);
      chk("zero_pulse", done, 0);
      @(posedge clk); #1;
      chk("zero_start_ignored", busy, 0);
      chk("zero_noreq", bus.dma_req_valid, 0);
      return;
    end
    chk("req_after_start", bus.dma_req_valid, 1);
    chk("done_low_start", done, 0);
    while (!fin) begin
      inj = (cur == err_req) && (bi == 1);
      bus.dma_req_ready = $urandom_range(0, 3) != 0;
      bus.buf_ready = $urandom_range(0, 3) != 0;
      bus.tile_ready = $urandom_range(0, 2) != 0;
      start = $urandom_range(0, 15) == 0;
      addr_base_a = $urandom; addr_base_b = $urandom;
      stride_a = 16'($urandom); stride_b = 16'($urandom);
      m = 16'($urandom_range(0, 3) * SIZE); k = 16'($urandom_range(0, 3) * SIZE); n = 16'($urandom_range(0, 3) * SIZE);
      bus.dma_data = {$urandom, $urandom};
      bus.dma_data_valid = pending ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.dma_data_last = pending ? ((bi == BEATS - 1) ^ inj) : 1'($urandom_range(0, 1));
      #1;
      if (abort_wait) begin
        chk("abort_done", done, 1);
        chk("abort_err", err, 1);
      end
      if (tile_wait) chk("done_after_tile", done, 1);
      if (done) begin
        fin = 1;
        chk("done_expected", abort_wait | tile_wait, 1);
        if (!abort_wait) begin
          chk("reqs_left", aq.size(), 0);
          chk("tiles_left", lq.size(), 0);
          chk("job_reqs", reqs, mt * nt * kt * 2 * SIZE);
          chk("job_tiles", tiles, mt * nt * kt);
          chk("err_clean", err, 0);
        end
      end else if (abort_wait || tile_wait) begin
        fin = 1;
      end
      if (!fin) begin
        wr = pending && bus.dma_data_valid && bus.buf_ready;
        chk("wr_en", bus.buf_wr_en, wr);
        if (!pending) chk("ready_idle", bus.dma_data_ready, 0);
        if (wr) begin
          j = cur % (2 * SIZE);
          chk("buf_sel", bus.buf_sel, j / SIZE);
          chk("buf_row", bus.buf_row, j % SIZE);
          chk("buf_beat", bus.buf_beat, bi);
          chk("buf_data", bus.buf_data, bus.dma_data);
          if (cur == rst_req && bi == 1) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_req", bus.dma_req_valid, 0);
            chk("rst_addr", bus.dma_req_addr, 0);
            chk("rst_wr", bus.buf_wr_en, 0);
            chk("rst_dready", bus.dma_data_ready, 0);
            chk("rst_tile", bus.tile_valid, 0);
            idle_inputs();
            @(posedge clk); #1;
            chk("rst_no_done", done, 0);
            rst = 1'b0;
            @(posedge clk); #1;
            chk("rst_after_done", done, 0);
            chk("rst_after_busy", busy, 0);
            return;
          end
          if (inj) begin
            pending = 0;
            abort_wait = 1;
          end else if (bi == BEATS - 1) begin
            pending = 0;
          end else begin
            bi++;
          end
        end
        if (bus.dma_req_valid) begin
          if (stall) chk("addr_stable", bus.dma_req_addr, prev_addr);
          chk("req_beats", bus.dma_req_beats, BEATS);
          if (bus.dma_req_ready) begin
            chk("req_expected", 32'(aq.size() > 0), 1);
            if (aq.size() > 0) chk("req_addr", bus.dma_req_addr, aq.pop_front());
            reqs++;
            cur++;
            pending = 1;
            bi = 0;
            stall = 0;
          end else begin
            stall = 1;
            prev_addr = bus.dma_req_addr;
          end
        end else begin
          stall = 0;
        end
        if (bus.tile_valid && bus.tile_ready) begin
          chk("tile_reqs", reqs, (tiles + 1) * 2 * SIZE);
          chk("tile_pend", pending, 0);
          chk("tile_expected", 32'(lq.size() > 0), 1);
          if (lq.size() > 0) chk("tile_last_k", bus.tile_last_k, lq.pop_front());
          tiles++;
          if (lq.size() == 0) tile_wait = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 20000) begin
        chk("timeout", cyc, 0);
        fin = 1;
      end
    end
    idle_inputs();
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
  endtask
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_req", bus.dma_req_valid, 0);
    chk("reset_addr", bus.dma_req_addr, 0);
    chk("reset_tile", bus.tile_valid, 0);
    chk("reset_lastk", bus.tile_last_k, 0);
    chk("reset_wr", bus.buf_wr_en, 0);
    chk("reset_dready", bus.dma_data_ready, 0);
    chk("reset_row", bus.buf_row, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(32'h1000_0010, 32'h2000_0100, 16'd32, 16'd32, 16'd8, 16'd8, 16'd8, -1, -1);
    run_job(32'h1000_0010, 32'h2000_0100, 16'd64, 16'd64, 16'd16, 16'd16, 16'd16, -1, -1);
    run_job($urandom, $urandom, 16'($urandom), 16'($urandom), 16'd16, 16'd24, 16'd8, -1, -1);
    run_job(32'hFFFF_FF00, 32'hFFFF_FFF0, 16'hFFF0, 16'h0100, 16'd8, 16'd16, 16'd16, -1, -1);
    run_job(32'h0000_4000, 32'h0000_8000, 16'd32, 16'd32, 16'd8, 16'd8, 16'd8, 5, -1);
    chk("err_sticky", err, 1);
    run_job(32'h0000_4000, 32'h0000_8000, 16'd32, 16'd32, 16'd8, 16'd8, 16'd8, -1, -1);
    run_job(32'h0000_4000, 32'h0000_8000, 16'd32, 16'd32, 16'd8, 16'd0, 16'd8, -1, -1);
    run_job(32'h3000_0000, 32'h4000_0000, 16'd128, 16'd96, 16'd16, 16'd16, 16'd16, -1, SIZE + 2);
    run_job(32'h3000_0000, 32'h4000_0000, 16'd128, 16'd96, 16'd16, 16'd16, 16'd16, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
